// File: rtl/uart_tx_sched.sv
// rtl/uart_tx_sched.sv - round-robin scheduler framing one requester word at a time onto a shared uart_tx
module uart_tx_sched #(
  parameter int NREQ  = 4,
  parameter int BYTES = 4
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [NREQ-1:0]         req_valid,
  input  logic [NREQ*8*BYTES-1:0] req_data,
  output logic [NREQ-1:0]         req_ready,
  output logic                    tx_en,
  output logic [7:0]              tx_data,
  input  logic                    uart_busy,
  output logic                    sched_busy,
  output logic [3:0]              grant_id
);

  localparam int W  = 8 * BYTES;
  localparam int CW = $clog2(BYTES + 1);
  localparam logic [CW-1:0] CNT_FULL = CW'(BYTES);

  typedef enum logic [1:0] {IDLE, SEND, WAIT_HI, WAIT_LO} state_t;

  state_t          state_q, state_d;
  logic [W-1:0]    shift_q, shift_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [3:0]      ptr_q, ptr_d;
  logic [3:0]      grant_q, grant_d;
  logic [NREQ-1:0] req_ready_q, req_ready_d;
  logic            tx_en_q, tx_en_d;
  logic [7:0]      tx_data_q, tx_data_d;
  logic            sched_busy_q, sched_busy_d;

  logic            win_found;
  logic            hi_found;
  logic [3:0]      win_hi, win_lo, win_id;
  logic [W-1:0]    win_word;
  logic            start;

  // Lowest valid index at/above ptr wins; otherwise wrap to the lowest valid overall.
  always_comb begin
    hi_found = 1'b0;
    win_hi   = '0;
    win_lo   = '0;
    for (int i = NREQ - 1; i >= 0; i--) begin
      if (req_valid[i]) begin
        win_lo = 4'(i);
        if (4'(i) >= ptr_q) begin
          win_hi   = 4'(i);
          hi_found = 1'b1;
        end
      end
    end
    win_found = |req_valid;
    win_id    = hi_found ? win_hi : win_lo;
  end

  always_comb begin
    win_word = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (win_id == 4'(i)) win_word = req_data[i*W +: W];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (win_found && !uart_busy) state_d = SEND;
      SEND:    state_d = WAIT_HI;
      WAIT_HI: if (uart_busy) state_d = WAIT_LO;
      WAIT_LO: if (!uart_busy) state_d = (cnt_q == '0) ? IDLE : SEND;
      default: state_d = IDLE;
    endcase
  end

  assign start = (state_q == IDLE) && (state_d == SEND);

  always_comb begin
    shift_d = shift_q;
    cnt_d   = cnt_q;
    ptr_d   = ptr_q;
    grant_d = grant_q;
    if (start) begin
      shift_d = win_word;
      cnt_d   = CNT_FULL;
      grant_d = win_id;
      ptr_d   = (win_id == 4'(NREQ - 1)) ? 4'd0 : win_id + 4'd1;
    end else if (state_q == WAIT_LO && state_d == SEND) begin
      // The header leaves the shift register untouched; only data bytes consume it.
      if (cnt_q != CNT_FULL) shift_d = shift_q << 8;
      cnt_d = cnt_q - CW'(1);
    end
  end

  always_comb begin
    req_ready_d  = '0;
    tx_en_d      = (state_d == SEND);
    tx_data_d    = tx_data_q;
    sched_busy_d = (state_d != IDLE);
    for (int i = 0; i < NREQ; i++) begin
      req_ready_d[i] = start && (win_id == 4'(i));
    end
    if (state_d == SEND) begin
      tx_data_d = (cnt_d == CNT_FULL) ? {4'hA, grant_d} : shift_d[W-1 -: 8];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      shift_q      <= '0;
      cnt_q        <= '0;
      ptr_q        <= '0;
      grant_q      <= '0;
      req_ready_q  <= '0;
      tx_en_q      <= 1'b0;
      tx_data_q    <= '0;
      sched_busy_q <= 1'b0;
    end else begin
      shift_q      <= shift_d;
      cnt_q        <= cnt_d;
      ptr_q        <= ptr_d;
      grant_q      <= grant_d;
      req_ready_q  <= req_ready_d;
      tx_en_q      <= tx_en_d;
      tx_data_q    <= tx_data_d;
      sched_busy_q <= sched_busy_d;
    end
  end

  assign req_ready  = req_ready_q;
  assign tx_en      = tx_en_q;
  assign tx_data    = tx_data_q;
  assign sched_busy = sched_busy_q;
  assign grant_id   = grant_q;

endmodule

// File: tb/tb_uart_tx_sched.sv
// tb/tb_uart_tx_sched.sv - scoreboard bench for uart_tx_sched with a behavioural uart_tx
module tb_uart_tx_sched;
  localparam int NREQ  = 4;
  localparam int BYTES = 4;
  localparam int W     = 8 * BYTES;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic [NREQ-1:0]   req_valid = '0;
  logic [NREQ*W-1:0] req_data = '0;
  logic [NREQ-1:0]   req_ready;
  logic              tx_en;
  logic [7:0]        tx_data;
  logic              uart_busy;
  logic              sched_busy;
  logic [3:0]        grant_id;

  int busy_cnt = 0;
  int n_checks = 0;
  int n_fail   = 0;
  int tx_count = 0;
  bit prev_en  = 1'b0;

  logic [W-1:0] drv_q [NREQ][$];
  logic [W-1:0] mdl_q [NREQ][$];
  int           mdl_ptr = 0;
  logic [7:0]   exp_bytes[$];
  int           exp_ready[$];

  uart_tx_sched #(.NREQ(NREQ), .BYTES(BYTES)) dut (
    .clk        (clk),
    .rst        (rst),
    .req_valid  (req_valid),
    .req_data   (req_data),
    .req_ready  (req_ready),
    .tx_en      (tx_en),
    .tx_data    (tx_data),
    .uart_busy  (uart_busy),
    .sched_busy (sched_busy),
    .grant_id   (grant_id)
  );

  always #5 clk = ~clk;

  // uart_tx stand-in: busy from the cycle after tx_en for 20 cycles.
  always @(posedge clk) begin
    if (tx_en)             busy_cnt <= 20;
    else if (busy_cnt > 0) busy_cnt <= busy_cnt - 1;
  end
  assign uart_busy = (busy_cnt != 0);

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic offer(input int i, input logic [W-1:0] d);
    drv_q[i].push_back(d);
    mdl_q[i].push_back(d);
  endtask

  // Reference: drain all pending words in round-robin order from the model pointer.
  task automatic predict();
    int w;
    logic [W-1:0] word;
    while (1) begin
      w = -1;
      for (int k = 0; k < NREQ; k++) begin
        if (w < 0 && mdl_q[(mdl_ptr + k) % NREQ].size() > 0) w = (mdl_ptr + k) % NREQ;
      end
      if (w < 0) break;
      word = mdl_q[w].pop_front();
      exp_ready.push_back(w);
      exp_bytes.push_back({4'hA, 4'(w)});
      for (int b = BYTES - 1; b >= 0; b--) exp_bytes.push_back(word[b*8 +: 8]);
      mdl_ptr = (w + 1) % NREQ;
    end
  endtask

  function automatic bit all_drained();
    bit e;
    e = (exp_bytes.size() == 0) && (exp_ready.size() == 0) && !sched_busy;
    for (int i = 0; i < NREQ; i++) if (drv_q[i].size() != 0) e = 1'b0;
    return e;
  endfunction

  task automatic drain(input string name, input int budget);
    int n;
    n = 0;
    while (!all_drained() && n < budget) begin
      @(negedge clk);
      n++;
    end
    chk(name, all_drained(), 1);
  endtask

  // Requester driver: present queue head, retire it on req_ready.
  initial begin
    forever begin
      @(posedge clk);
      #1;
      for (int i = 0; i < NREQ; i++) begin
        if (req_ready[i] && drv_q[i].size() > 0) void'(drv_q[i].pop_front());
        req_valid[i] = (drv_q[i].size() > 0);
        req_data[i*W +: W] = (drv_q[i].size() > 0) ? drv_q[i][0] : '0;
      end
    end
  end

  // Monitor: every byte and every accept is popped from the scoreboard.
  initial begin
    forever begin
      @(negedge clk);
      if (rst) begin
        prev_en = 1'b0;
      end else begin
        if (tx_en) begin
          chk("tx_en_width", prev_en, 0);
          chk("tx_en_while_busy", uart_busy, 0);
          if (exp_bytes.size() == 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL unexpected_byte: got 0x%0h, expected none at %0t", tx_data, $time);
          end else begin
            chk("tx_byte", tx_data, exp_bytes.pop_front());
          end
          tx_count++;
        end
        if (|req_ready) begin
          chk("ready_onehot", $onehot(req_ready), 1);
          if (exp_ready.size() == 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL unexpected_ready: got 0x%0h, expected none at %0t", req_ready, $time);
          end else begin
            chk("ready_id", req_ready, NREQ'(1) << exp_ready.pop_front());
          end
        end
        prev_en = tx_en;
      end
    end
  end

  initial begin
    #800000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int base;
    int n;
    int cnt;
    repeat (3) @(negedge clk);
    chk("rst_req_ready", req_ready, 0);
    chk("rst_tx_en", tx_en, 0);
    chk("rst_tx_data", tx_data, 0);
    chk("rst_sched_busy", sched_busy, 0);
    chk("rst_grant_id", grant_id, 0);
    rst = 1'b0;
    @(negedge clk);

    offer(0, 32'h12345678);
    predict();
    drain("single_done", 2000);

    offer(2, W'($urandom));
    predict();
    drain("rr_first_done", 2000);
    offer(0, W'($urandom));
    offer(2, W'($urandom));
    predict();
    drain("rr_wrap_done", 3000);

    for (int i = 0; i < NREQ; i++) offer(i, W'($urandom));
    offer(0, W'($urandom));
    predict();
    drain("all_valid_done", 6000);

    offer(1, W'($urandom));
    predict();
    repeat (40) @(negedge clk);
    chk("midframe_busy", sched_busy, 1);
    offer(3, W'($urandom));
    predict();
    drain("midframe_done", 3000);

    offer(3, W'($urandom));
    predict();
    repeat (15) @(negedge clk);
    drv_q[1].push_back(W'($urandom));
    offer(2, W'($urandom));
    predict();
    repeat (20) @(negedge clk);
    drv_q[1].delete();
    drain("withdraw_done", 3000);

    offer(1, W'($urandom));
    predict();
    base = tx_count;
    n = 0;
    while (tx_count < base + 3 && n < 500) begin
      @(negedge clk);
      n++;
    end
    chk("third_byte_seen", tx_count >= base + 3, 1);
    repeat (5) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    chk("midrst_tx_en", tx_en, 0);
    chk("midrst_sched_busy", sched_busy, 0);
    chk("midrst_grant_id", grant_id, 0);
    chk("midrst_req_ready", req_ready, 0);
    exp_bytes.delete();
    exp_ready.delete();
    mdl_ptr = 0;
    for (int i = 0; i < NREQ; i++) begin
      drv_q[i].delete();
      mdl_q[i].delete();
    end
    rst = 1'b0;
    offer(3, W'($urandom));
    offer(1, W'($urandom));
    predict();
    drain("after_rst_done", 3000);

    for (int t = 0; t < 8; t++) begin
      for (int i = 0; i < NREQ; i++) begin
        cnt = $urandom_range(0, 2);
        for (int k = 0; k < cnt; k++) offer(i, W'($urandom));
      end
      offer($urandom_range(0, NREQ - 1), W'($urandom));
      predict();
      drain("random_batch_done", 8000);
      repeat ($urandom_range(0, 3)) @(negedge clk);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
